// File: rtl/mdu_sequencer.sv
// mdu_sequencer
//
// Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
// It accepts one MUL/DIV/REM operation and runs it over XLEN clock cycles.
// Multiplies use a shift-add core and divides use a restoring core.
// While it works it raises busy so the hazard logic can stall IF/ID/EX.
// It returns one registered result together with a single-cycle done pulse.
// Divide-by-zero and signed-overflow divides finish in one cycle.
// A taken branch (flush) aborts the operation in flight.
//
// Ports
//   clk     in   1     rising-edge clock
//   rst_n   in   1     asynchronous active-low reset
//   start   in   1     operation request, sampled only while idle
//   op      in   3     funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU,
//                              4 DIV, 5 DIVU, 6 REM, 7 REMU
//   in1     in   XLEN  rs1 operand, captured when start is accepted
//   in2     in   XLEN  rs2 operand, captured when start is accepted
//   flush   in   1     abort the current operation; blocks a same-cycle start
//   busy    out  1     unit is not idle; used as the pipeline stall request
//   done    out  1     one-cycle pulse, result is valid in this cycle
//   result  out  XLEN  registered result, held until the next done

module mdu_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [2:0] OpMul    = 3'd0;
    localparam logic [2:0] OpMulh   = 3'd1;
    localparam logic [2:0] OpMulhsu = 3'd2;
    localparam logic [2:0] OpMulhu  = 3'd3;
    localparam logic [2:0] OpDiv    = 3'd4;
    localparam logic [2:0] OpDivu   = 3'd5;
    localparam logic [2:0] OpRem    = 3'd6;
    localparam logic [2:0] OpRemu   = 3'd7;

    localparam logic [XLEN-1:0]  MinNeg   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(XLEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2:0]        op_q;
    // Multiplicand (multiply) or divisor magnitude (divide).
    logic [XLEN-1:0]   opnd_q;
    // Multiply: {partial product high, multiplier shifting out / product low}.
    // Divide:   {partial remainder, dividend shifting out / quotient in}.
    logic [2*XLEN-1:0] acc_q;
    // The unsigned core result must be negated at the end.
    logic              neg_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    // ------------------------------------------------------------------
    // Capture-side decode: sign handling and one-cycle special cases
    // ------------------------------------------------------------------
    logic              is_div;
    logic              in1_signed;
    logic              in2_signed;
    logic              in1_neg;
    logic              in2_neg;
    logic [XLEN-1:0]   in1_mag;
    logic [XLEN-1:0]   in2_mag;
    logic              neg_init;
    logic              div_zero;
    logic              div_ovf;
    logic              fast;
    logic [XLEN-1:0]   fast_res;
    logic [XLEN-1:0]   opnd_init;
    logic [2*XLEN-1:0] acc_init;

    always_comb begin
        is_div     = op[2];
        in1_signed = (op == OpMulh) || (op == OpMulhsu) || (op == OpDiv) || (op == OpRem);
        in2_signed = (op == OpMulh) || (op == OpDiv) || (op == OpRem);
        in1_neg    = in1_signed && in1[XLEN-1];
        in2_neg    = in2_signed && in2[XLEN-1];
        // The most negative value maps to its own bit pattern.
        // That pattern is the correct unsigned magnitude.
        in1_mag    = in1_neg ? -in1 : in1;
        in2_mag    = in2_neg ? -in2 : in2;

        // Remainder takes the dividend's sign.
        // Products and quotients take the XOR of the operand signs.
        if ((op == OpRem) || (op == OpRemu)) begin
            neg_init = in1_neg;
        end else begin
            neg_init = in1_neg ^ in2_neg;
        end

        div_zero = is_div && (in2 == '0);
        div_ovf  = ((op == OpDiv) || (op == OpRem)) && (in1 == MinNeg) && (in2 == '1);
        fast     = div_zero || div_ovf;

        // op[1] separates REM/REMU from DIV/DIVU within the divide group.
        if (div_zero) begin
            fast_res = op[1] ? in1 : '1;
        end else begin
            fast_res = op[1] ? '0 : MinNeg;
        end

        if (is_div) begin
            acc_init  = {{XLEN{1'b0}}, in1_mag};
            opnd_init = in2_mag;
        end else begin
            acc_init  = {{XLEN{1'b0}}, in2_mag};
            opnd_init = in1_mag;
        end
    end

    // ------------------------------------------------------------------
    // One iteration of the active core, plus final sign fix-up
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] acc_step;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0]   quo_fin;
    logic [XLEN-1:0]   rem_fin;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        // Shift-add: add the multiplicand into the high half when the
        // current multiplier bit is set. Then shift the whole accumulator
        // right, with the add carry entering at the top.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};

        // Restoring divide: the guard bit holds the remainder MSB shifted
        // out. A compare stands in for the trial subtract's borrow.
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, opnd_q});
        div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];

        if (op_q[2]) begin
            acc_step = {div_rem, acc_q[XLEN-2:0], div_ge};
        end else if (acc_q[0]) begin
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        end else begin
            acc_step = {1'b0, acc_q[2*XLEN-1:1]};
        end

        // Result once the last iteration (acc_step) has been applied.
        prod_fin = neg_q ? -acc_step : acc_step;
        quo_fin  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
        rem_fin  = neg_q ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];

        case (op_q)
            OpMul:                      final_res = prod_fin[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu:  final_res = prod_fin[2*XLEN-1:XLEN];
            OpDiv, OpDivu:              final_res = quo_fin;
            default:                    final_res = rem_fin;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start && !flush) begin
                        op_q   <= op;
                        opnd_q <= opnd_init;
                        acc_q  <= acc_init;
                        neg_q  <= neg_init;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (fast) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= fast_res;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (flush) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LastIter) begin
                            state_q  <= StDone;
                            done_q   <= 1'b1;
                            result_q <= final_res;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Self-checking bench for mdu_sequencer.
// The reference model computes RV32M results with 64-bit integer arithmetic.

module tb_mdu_sequencer;

    localparam int MAXC = 40;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations from the most recent run_op call.
    int          obs_done_cyc;
    int          obs_done_cnt;
    logic [63:0] obs_busy;
    logic [31:0] obs_res;
    logic [31:0] obs_res_end;

    mdu_sequencer #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .in1    (in1),
        .in2    (in2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] ref_mdu(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        int              qa;
        int              qb;
        logic [31:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        qa = $signed(a);
        qb = $signed(b);
        r  = '0;
        case (o)
            3'd0: begin p = ua * ub;          r = p[31:0];  end
            3'd1: begin p = sa * sb;          r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub;          r = p[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else r = 32'(qa / qb);
            end
            3'd5: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else r = a / b;
            end
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else r = 32'(qa % qb);
            end
            default: begin
                if (b == 0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
        bit f;
        f = o[2] && ((b == 0) ||
            ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
        return f ? 1 : 33;
    endfunction

    function automatic logic [31:0] rand_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'h0000_0000;
            1: v = 32'h0000_0001;
            2: v = 32'hFFFF_FFFF;
            3: v = 32'h8000_0000;
            4: v = 32'h7FFF_FFFF;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Driver: issue one op (called just after a falling edge), observe
    // up to MAXC cycles. hold keeps start high with junk until done.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit hold, input bit stop_on_done);
        start = 1'b1;
        op    = o;
        in1   = a;
        in2   = b;
        @(posedge clk);
        #1;
        start = hold;
        op    = 3'($urandom);
        in1   = $urandom;
        in2   = $urandom;
        obs_done_cyc = 0;
        obs_done_cnt = 0;
        obs_busy     = '0;
        obs_res      = '0;
        for (int k = 1; k <= MAXC; k++) begin
            @(negedge clk);
            obs_busy[k] = busy;
            if (done === 1'b1) begin
                obs_done_cnt++;
                if (obs_done_cyc == 0) begin
                    obs_done_cyc = k;
                    obs_res      = result;
                end
            end
            if (hold && obs_done_cyc == 0) begin
                start = 1'b1;
                op    = 3'($urandom);
                in1   = $urandom;
                in2   = $urandom;
            end else begin
                start = 1'b0;
            end
            if (stop_on_done && obs_done_cyc != 0 && k == obs_done_cyc + 1) break;
        end
        obs_res_end = result;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset busy: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL reset done: got %b required 0", done);
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset result: got %h required 0", result);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL post-reset busy: got %b required 0", busy);
        else n_pass++;
    endtask

    typedef struct packed {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [7:0]  lat;
    } vec_t;

    vec_t dir_vecs [11] = '{
        '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd33},
        '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd33},
        '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 8'd33},
        '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd33},
        '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 8'd33},
        '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 8'd33},
        '{3'd5, 32'd100,       32'd7,         32'd14,        8'd33},
        '{3'd7, 32'd100,       32'd7,         32'd2,         8'd33},
        '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 8'd1},
        '{3'd6, 32'd5,         32'd0,         32'd5,         8'd1},
        '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 8'd1}
    };

    task automatic test_directed();
        bit bok;
        int lat;
        for (int i = 0; i < 11; i++) begin
            lat = int'(dir_vecs[i].lat);
            run_op(dir_vecs[i].o, dir_vecs[i].a, dir_vecs[i].b, 1'b0, 1'b0);
            n_checks++;
            if (obs_res !== dir_vecs[i].r)
                $display("FAIL directed[%0d] result: got %h required %h", i, obs_res,
                         dir_vecs[i].r);
            else n_pass++;
            n_checks++;
            if (obs_done_cyc != lat)
                $display("FAIL directed[%0d] done cycle: got %0d required %0d", i,
                         obs_done_cyc, lat);
            else n_pass++;
            n_checks++;
            if (obs_done_cnt != 1)
                $display("FAIL directed[%0d] done count: got %0d required 1", i, obs_done_cnt);
            else n_pass++;
            bok = 1'b1;
            for (int k = 1; k <= lat + 1; k++) if (obs_busy[k] !== (k <= lat)) bok = 1'b0;
            n_checks++;
            if (!bok)
                $display("FAIL directed[%0d] busy window: got %h required ones in 1..%0d", i,
                         obs_busy, lat);
            else n_pass++;
            n_checks++;
            if (obs_res_end !== dir_vecs[i].r)
                $display("FAIL directed[%0d] result hold: got %h required %h", i, obs_res_end,
                         dir_vecs[i].r);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom);
            a = rand_opnd();
            b = rand_opnd();
            exp_r = ref_mdu(o, a, b);
            run_op(o, a, b, 1'b0, 1'b0);
            n_checks++;
            if (obs_res !== exp_r)
                $display("FAIL random[%0d] op%0d %h,%h result: got %h required %h", i, o, a, b,
                         obs_res, exp_r);
            else n_pass++;
            n_checks++;
            if (obs_done_cyc != ref_lat(o, a, b))
                $display("FAIL random[%0d] done cycle: got %0d required %0d", i, obs_done_cyc,
                         ref_lat(o, a, b));
            else n_pass++;
            n_checks++;
            if (obs_done_cnt != 1)
                $display("FAIL random[%0d] done count: got %0d required 1", i, obs_done_cnt);
            else n_pass++;
            n_checks++;
            if (obs_res_end !== exp_r)
                $display("FAIL random[%0d] result hold: got %h required %h", i, obs_res_end,
                         exp_r);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        for (int i = 0; i < 10; i++) begin
            o   = 3'($urandom);
            a   = rand_opnd();
            b   = rand_opnd();
            lat = ref_lat(o, a, b);
            run_op(o, a, b, 1'b0, 1'b1);
            n_checks++;
            if (obs_res !== ref_mdu(o, a, b))
                $display("FAIL b2b[%0d] result: got %h required %h", i, obs_res,
                         ref_mdu(o, a, b));
            else n_pass++;
            n_checks++;
            if (obs_done_cyc != lat)
                $display("FAIL b2b[%0d] done cycle: got %0d required %0d", i, obs_done_cyc, lat);
            else n_pass++;
            n_checks++;
            if (obs_busy[lat + 1] !== 1'b0)
                $display("FAIL b2b[%0d] busy after done: got %b required 0", i,
                         obs_busy[lat + 1]);
            else n_pass++;
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_flush();
        logic [31:0] prior;
        logic [31:0] a;
        logic [31:0] b;
        int          dcount;
        prior = result;
        start = 1'b1;
        op    = 3'd0;
        in1   = $urandom;
        in2   = $urandom;
        @(posedge clk);
        #1;
        start  = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
            if (k == 10) flush = 1'b1;
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL flush busy cycle 11: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0 || dcount != 0)
            $display("FAIL flush done: got done=%b earlier=%0d required none", done, dcount);
        else n_pass++;
        n_checks++;
        if (result !== prior) $display("FAIL flush result: got %h required %h", result, prior);
        else n_pass++;

        a = $urandom;
        b = $urandom;
        run_op(3'd0, a, b, 1'b0, 1'b0);
        n_checks++;
        if (obs_res !== ref_mdu(3'd0, a, b))
            $display("FAIL after-flush result: got %h required %h", obs_res, ref_mdu(3'd0, a, b));
        else n_pass++;
        n_checks++;
        if (obs_done_cyc != 33)
            $display("FAIL after-flush done cycle: got %0d required 33", obs_done_cyc);
        else n_pass++;

        // flush while idle blocks a same-cycle start
        start = 1'b1;
        flush = 1'b1;
        op    = 3'd5;
        in1   = 32'd9;
        in2   = 32'd0;
        @(posedge clk);
        #1;
        start  = 1'b0;
        flush  = 1'b0;
        dcount = 0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle flush blocks start: got busy=%b done=%b required 0/0", busy, done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int dcount;
        int bcount;
        start = 1'b1;
        op    = 3'd4;
        in1   = 32'd1000 + 32'($urandom_range(0, 999));
        in2   = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 15; k++) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL mid reset busy: got %b required 0", busy);
        else n_pass++;
        n_checks++;
        if (done !== 1'b0) $display("FAIL mid reset done: got %b required 0", done);
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL mid reset result: got %h required 0", result);
        else n_pass++;
        @(negedge clk);
        rst_n  = 1'b1;
        dcount = 0;
        bcount = 0;
        for (int k = 0; k < MAXC; k++) begin
            @(negedge clk);
            if (done === 1'b1) dcount++;
            if (busy !== 1'b0) bcount++;
        end
        n_checks++;
        if (dcount != 0 || bcount != 0)
            $display("FAIL abandoned op: got %0d done and %0d busy cycles required 0/0",
                     dcount, bcount);
        else n_pass++;
    endtask

    task automatic test_hold_start();
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 3; i++) begin
            o = 3'($urandom);
            a = $urandom & 32'h7FFF_FFFF;
            b = $urandom | 32'h1;
            run_op(o, a, b, 1'b1, 1'b0);
            n_checks++;
            if (obs_done_cnt != 1)
                $display("FAIL hold[%0d] done count: got %0d required 1", i, obs_done_cnt);
            else n_pass++;
            n_checks++;
            if (obs_res !== ref_mdu(o, a, b))
                $display("FAIL hold[%0d] result: got %h required %h", i, obs_res,
                         ref_mdu(o, a, b));
            else n_pass++;
            n_checks++;
            if (obs_done_cyc != 33)
                $display("FAIL hold[%0d] done cycle: got %0d required 33", i, obs_done_cyc);
            else n_pass++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        in1   = 32'h0;
        in2   = 32'h0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_hold_start();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
